sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester arbiter and sequencer in front of `sram_interface`. It accepts fabric-side requests from ports A and B and grants them round-robin. It drives the granted request into `sram_interface` from registers and routes read data back to the requester that issued it. Reads block further issue until their data returns, so the `conf`/subaddress pipelined inside `sram_interface` stays valid for the output shifter. Writes issue back-to-back.

## Interface
- `RD_LAT`, default 2: cycles from the arbiter driving a read onto `sif_*` to `sif_dout` valid, with `sram_interface` output register off.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `a_req`, `b_req`  in  1 each  request; held with payload until granted.
- `a_we`, `b_we`  in  1 each  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  14 each  `{subaddr[4:0], baseaddr[8:0]}`.
- `a_conf`, `b_conf`  in  3 each  width configuration.
- `a_wdata`, `b_wdata`  in  32 each  write data.
- `a_gnt`, `b_gnt`  out  1 each  combinational accept, same cycle as req.
- `a_rvalid`, `b_rvalid`  out  1 each  one-cycle read-data-valid pulse.
- `a_rdata`, `b_rdata`  out  32 each  read data, held until the next rvalid on that port.
- `sif_csb`  out  1  active-low select to `sram_interface`.
- `sif_web`  out  1  active-low write to `sram_interface`.
- `sif_addr`  out  14  address to `sram_interface`.
- `sif_conf`  out  3  configuration to `sram_interface`.
- `sif_din`  out  32  write data to `sram_interface`.
- `sif_out_reg`  out  1  output-register select for `sram_interface`.
- `sif_dout`  in  32  `d_fabric_out` from `sram_interface`.

## Operation
- States:
  - IDLE: grants allowed.
  - RD_WAIT: counter `cnt` running; no grants.
- Arbitration in IDLE:
  - If only one port requests, that port is granted.
  - If both request, the port named by `prio` is granted.
  - `prio` flips to the other port after every grant. Reset value: A.
- At most one gnt per cycle. Never grant in RD_WAIT or while `rst` is high.
- Grant in cycle G: the payload is registered onto `sif_addr`, `sif_conf`, `sif_din`, `sif_web` (= ~we) and `sif_csb` = 0, driven in cycle G+1 only.
- In any cycle without a new issue:
  - `sif_csb` = 1, `sif_web` = 1.
  - `sif_addr`, `sif_conf`, `sif_din` hold their last values.
- Write grant: stay IDLE; a new grant is legal in G+1.
- Read grant:
  - Go to RD_WAIT and load `cnt` = L, where L = RD_LAT+1 (+1 if outreg).
  - Record the issuing port in `tag`.
  - `cnt` decrements each cycle.
  - In the cycle `cnt` = 1, capture `sif_dout` into the tagged port's `rdata`, then return to IDLE.
- rvalid on the tagged port pulses the cycle after capture, which is also the first cycle a new grant is legal.
- Reset:
  - State IDLE, `cnt` = 0, `prio` = A.
  - `sif_csb` = 1, `sif_web` = 1.
  - `sif_addr`, `sif_conf`, `sif_din` = 0.
  - Both rvalid = 0, both rdata = 0.
- Reset mid-read: pending data is discarded; no rvalid follows.

## Timing
- Grant to `sif_csb` low: 1 cycle.
- Read grant in cycle G:
  - `sif_dout` valid in cycle G+1+L−1.
  - rvalid in cycle G+L+1; default G+4, or G+5 with outreg.
- Next grant after a read: earliest in cycle G+L+1.
- Write throughput: one write per cycle.
- Read throughput: one read per L+1 cycles.
- A request raised during RD_WAIT waits; gnt asserts in the first IDLE cycle.

## Configuration
- `SRAM_ARB_OUTREG_EN` defined:
  - `sif_out_reg` tied 1.
  - L = RD_LAT+2; read-to-rvalid latency +1.
- Not defined:
  - `sif_out_reg` tied 0.
  - L = RD_LAT+1.

## Test plan
- Reset, then idle: `sif_csb` = 1, `sif_web` = 1, all gnt/rvalid 0, `sif_addr` = 0.
- `a_req` write, addr 0x0005, wdata 0xDEADBEEF in cycle 0:
  - `a_gnt` = 1 in cycle 0.
  - Cycle 1: `sif_csb` = 0, `sif_web` = 0, `sif_din` = 0xDEADBEEF.
  - Cycle 2: `sif_csb` = 1.
- Both ports request writes continuously for 4 cycles: gnt alternates A, B, A, B; `sif_csb` low cycles 1–4.
- `b_req` read in cycle 0 while the model returns 0x12345678 on `sif_dout` in cycle 3:
  - `b_rvalid` pulses in cycle 4 with `b_rdata` = 0x12345678.
  - `a_req` held from cycle 1 is not granted before cycle 4.
  - `sif_conf` and `sif_addr` stay constant in cycles 1–3.
- Same read with `SRAM_ARB_OUTREG_EN`: `sif_out_reg` = 1; data sampled in cycle 4; rvalid in cycle 5.
- `rst` pulsed in cycle 2 of an A read: no `a_rvalid` ever asserts; `prio` = A afterward; a B-only request is granted the cycle after `rst` falls.

Source files
------------

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sram_arbiter_if                                                |
// | Brief   : Fabric ports A/B and sram_interface bus seen by sram_arbiter.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface sram_arbiter_if;
  logic        a_req, b_req;
  logic        a_we, b_we;
  logic [13:0] a_addr, b_addr;
  logic [2:0]  a_conf, b_conf;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt;
  logic        a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;

  logic        sif_csb;
  logic        sif_web;
  logic [13:0] sif_addr;
  logic [2:0]  sif_conf;
  logic [31:0] sif_din;
  logic        sif_out_reg;
  logic [31:0] sif_dout;

  // Arbiter side
  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_conf, b_conf,
           a_wdata, b_wdata, sif_dout,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           sif_csb, sif_web, sif_addr, sif_conf, sif_din, sif_out_reg
  );

  // Requesters and SRAM side
  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_conf, b_conf,
           a_wdata, b_wdata, sif_dout,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           sif_csb, sif_web, sif_addr, sif_conf, sif_din, sif_out_reg
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sram_arbiter                                                   |
// | Brief   : Round-robin A/B arbiter sequencing requests into               |
// |           sram_interface; reads block issue until their data returns.    |
// |           Optional macro SRAM_ARB_OUTREG_EN enables the SRAM output reg.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sram_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

`ifdef SRAM_ARB_OUTREG_EN
  localparam int   c_LAT    = RD_LAT + 2;
  localparam logic c_OUTREG = 1'b1;
`else
  localparam int   c_LAT    = RD_LAT + 1;
  localparam logic c_OUTREG = 1'b0;
`endif
  localparam int c_CW = $clog2(c_LAT + 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_prio;   // 0 = A preferred, 1 = B preferred
  logic            r_tag;    // port owning the outstanding read
  logic            r_csb;
  logic            r_web;
  logic [13:0]     r_addr;
  logic [2:0]      r_conf;
  logic [31:0]     r_din;
  logic            r_a_rvalid;
  logic            r_b_rvalid;
  logic [31:0]     r_a_rdata;
  logic [31:0]     r_b_rdata;

  logic            w_idle;
  logic            w_gnt_a;
  logic            w_gnt_b;
  logic            w_we;
  logic [13:0]     w_addr;
  logic [2:0]      w_conf;
  logic [31:0]     w_wdata;

  assign w_idle  = (r_state == S_IDLE) && !rst;
  assign w_gnt_a = w_idle && bus.a_req && (!bus.b_req || !r_prio);
  assign w_gnt_b = w_idle && bus.b_req && (!bus.a_req ||  r_prio);

  assign w_we    = w_gnt_b ? bus.b_we    : bus.a_we;
  assign w_addr  = w_gnt_b ? bus.b_addr  : bus.a_addr;
  assign w_conf  = w_gnt_b ? bus.b_conf  : bus.a_conf;
  assign w_wdata = w_gnt_b ? bus.b_wdata : bus.a_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_prio     <= 1'b0;
      r_tag      <= 1'b0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_addr     <= '0;
      r_conf     <= '0;
      r_din      <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_a || w_gnt_b) begin
            r_csb  <= 1'b0;
            r_web  <= ~w_we;
            r_addr <= w_addr;
            r_conf <= w_conf;
            r_din  <= w_wdata;
            r_prio <= ~r_prio;
            if (!w_we) begin
              r_state <= S_RD_WAIT;
              r_cnt   <= c_CW'(c_LAT);
              r_tag   <= w_gnt_b;
            end
          end
        end
        S_RD_WAIT: begin
          r_cnt <= r_cnt - c_CW'(1);
          // Last wait cycle: sif_dout is valid now, rvalid follows next cycle
          if (r_cnt == c_CW'(1)) begin
            if (r_tag) begin
              r_b_rdata  <= bus.sif_dout;
              r_b_rvalid <= 1'b1;
            end else begin
              r_a_rdata  <= bus.sif_dout;
              r_a_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_gnt       = w_gnt_a;
  assign bus.b_gnt       = w_gnt_b;
  assign bus.a_rvalid    = r_a_rvalid;
  assign bus.b_rvalid    = r_b_rvalid;
  assign bus.a_rdata     = r_a_rdata;
  assign bus.b_rdata     = r_b_rdata;
  assign bus.sif_csb     = r_csb;
  assign bus.sif_web     = r_web;
  assign bus.sif_addr    = r_addr;
  assign bus.sif_conf    = r_conf;
  assign bus.sif_din     = r_din;
  assign bus.sif_out_reg = c_OUTREG;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sram_arbiter                                                |
// | Brief   : Directed and random stimulus against a cycle-schedule model.   |
// |           Honours SRAM_ARB_OUTREG_EN like the design.                    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sram_arbiter;
  localparam int RD_LAT = 2;
`ifdef SRAM_ARB_OUTREG_EN
  localparam int   LAT  = RD_LAT + 2;
  localparam logic OREG = 1'b1;
`else
  localparam int   LAT  = RD_LAT + 1;
  localparam logic OREG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: expected registered outputs for the current cycle plus a schedule
  int          cyc, next_ok, cap_cyc;
  logic        prio, rd_pend, rd_port, last_ga, last_gb;
  logic        e_csb, e_web, e_arv, e_brv;
  logic [13:0] e_addr;
  logic [2:0]  e_conf;
  logic [31:0] e_din, e_ard, e_brd;

  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.RD_LAT(RD_LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prio = 1'b0; rd_pend = 1'b0; rd_port = 1'b0; cap_cyc = 0;
    next_ok = cyc + 1;
    e_csb = 1'b1; e_web = 1'b1; e_arv = 1'b0; e_brv = 1'b0;
    e_addr = '0; e_conf = '0; e_din = '0; e_ard = '0; e_brd = '0;
  endtask

  task automatic eval();
    logic ready, ga, gb, we;
    ready = !rst && (cyc >= next_ok);
    ga = ready && bus.a_req && (!bus.b_req || !prio);
    gb = ready && bus.b_req && (!bus.a_req ||  prio);
    chk("a_gnt",    32'(bus.a_gnt),       32'(ga));
    chk("b_gnt",    32'(bus.b_gnt),       32'(gb));
    chk("sif_csb",  32'(bus.sif_csb),     32'(e_csb));
    chk("sif_web",  32'(bus.sif_web),     32'(e_web));
    chk("sif_addr", 32'(bus.sif_addr),    32'(e_addr));
    chk("sif_conf", 32'(bus.sif_conf),    32'(e_conf));
    chk("sif_din",  bus.sif_din,          e_din);
    chk("out_reg",  32'(bus.sif_out_reg), 32'(OREG));
    chk("a_rvalid", 32'(bus.a_rvalid),    32'(e_arv));
    chk("b_rvalid", 32'(bus.b_rvalid),    32'(e_brv));
    chk("a_rdata",  bus.a_rdata,          e_ard);
    chk("b_rdata",  bus.b_rdata,          e_brd);

    e_csb = 1'b1; e_web = 1'b1; e_arv = 1'b0; e_brv = 1'b0;
    if (rd_pend && cyc == cap_cyc) begin
      if (rd_port) begin e_brd = bus.sif_dout; e_brv = 1'b1; end
      else         begin e_ard = bus.sif_dout; e_arv = 1'b1; end
      rd_pend = 1'b0;
    end
    if (ga || gb) begin
      we     = gb ? bus.b_we    : bus.a_we;
      e_addr = gb ? bus.b_addr  : bus.a_addr;
      e_conf = gb ? bus.b_conf  : bus.a_conf;
      e_din  = gb ? bus.b_wdata : bus.a_wdata;
      e_csb  = 1'b0;
      e_web  = ~we;
      prio   = ~prio;
      if (!we) begin
        rd_pend = 1'b1; rd_port = gb;
        cap_cyc = cyc + LAT; next_ok = cyc + LAT + 1;
      end
    end
    if (rst) model_reset();
    last_ga = ga; last_gb = gb;
    cyc++;
  endtask

  task automatic at_neg();
    @(negedge clk);
    eval();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    bus.sif_dout = $urandom();
  endtask

  task automatic b_write(input logic [13:0] addr);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = addr;
    bus.b_conf = 3'd1; bus.b_wdata = $urandom();
    at_neg(); next();
    bus.b_req = 1'b0;
  endtask

  // A read interrupted by reset in its cycle 2
  task automatic rd_reset(input logic both);
    b_write(14'h0033);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 14'h0100; bus.a_conf = 3'd4;
    at_neg(); chk("rr_a_gnt", 32'(bus.a_gnt), 32'd1); next();
    bus.a_req = 1'b0;
    at_neg(); next();
    rst = 1'b1;
    at_neg(); next();
    rst = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 14'h0044; bus.b_wdata = 32'h0BADF00D;
    if (both) begin
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 14'h0055; bus.a_wdata = 32'h600DF00D;
    end
    at_neg();
    if (both) chk("rr_prio_a_after_rst", 32'(bus.a_gnt), 32'd1);
    else      chk("rr_b_gnt_after_rst",  32'(bus.b_gnt), 32'd1);
    next();
    bus.a_req = 1'b0;
    if (!both) bus.b_req = 1'b0;
    at_neg(); next();
    bus.b_req = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      at_neg(); chk("rr_no_a_rvalid", 32'(bus.a_rvalid), 32'd0); next();
    end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_conf = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_conf = '0; bus.b_wdata = '0;
    bus.sif_dout = '0;
    cyc = 0; last_ga = 1'b0; last_gb = 1'b0;
    model_reset();
    next_ok = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Idle after reset
    at_neg();
    chk("rst_csb",  32'(bus.sif_csb),  32'd1);
    chk("rst_web",  32'(bus.sif_web),  32'd1);
    chk("rst_addr", 32'(bus.sif_addr), 32'd0);
    chk("rst_gnt",  32'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}), 32'd0);
    next();

    // Single A write
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 14'h0005;
    bus.a_conf = 3'd3; bus.a_wdata = 32'hDEADBEEF;
    at_neg(); chk("wr_a_gnt", 32'(bus.a_gnt), 32'd1); next();
    bus.a_req = 1'b0;
    at_neg();
    chk("wr_csb_low", 32'(bus.sif_csb), 32'd0);
    chk("wr_web_low", 32'(bus.sif_web), 32'd0);
    chk("wr_din",     bus.sif_din,      32'hDEADBEEF);
    next();
    at_neg(); chk("wr_csb_high", 32'(bus.sif_csb), 32'd1); next();

    // Restore A priority, then both ports write continuously
    b_write(14'h0006);
    for (int i = 0; i < 4; i++) begin
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 14'(16 + i); bus.a_wdata = $urandom();
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 14'(32 + i); bus.b_wdata = $urandom();
      at_neg();
      chk("rr_alt_a", 32'(bus.a_gnt), 32'(i % 2 == 0));
      chk("rr_alt_b", 32'(bus.b_gnt), 32'(i % 2 == 1));
      if (i > 0) chk("rr_csb_low", 32'(bus.sif_csb), 32'd0);
      next();
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    at_neg(); chk("rr_csb_low_last", 32'(bus.sif_csb), 32'd0); next();
    at_neg(); next();

    // B read, A write request blocked until the read completes
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 14'h02A7; bus.b_conf = 3'd5;
    at_neg(); chk("rd_b_gnt", 32'(bus.b_gnt), 32'd1); next();
    bus.b_req = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 14'h0011;
    bus.a_conf = 3'd2; bus.a_wdata = 32'hCAFEF00D;
    for (int c = 1; c <= LAT; c++) begin
      if (c == LAT) bus.sif_dout = 32'h12345678;
      at_neg();
      chk("rd_a_blocked", 32'(bus.a_gnt),       32'd0);
      chk("rd_addr_hold", 32'(bus.sif_addr),    32'h02A7);
      chk("rd_conf_hold", 32'(bus.sif_conf),    32'd5);
      chk("rd_out_reg",   32'(bus.sif_out_reg), 32'(OREG));
      next();
    end
    at_neg();
    chk("rd_b_rvalid", 32'(bus.b_rvalid), 32'd1);
    chk("rd_b_rdata",  bus.b_rdata,       32'h12345678);
    chk("rd_a_gnt",    32'(bus.a_gnt),    32'd1);
    next();
    bus.a_req = 1'b0;
    at_neg(); chk("rd_b_rvalid_pulse", 32'(bus.b_rvalid), 32'd0); next();

    // Reset during an outstanding read
    rd_reset(1'b0);
    rd_reset(1'b1);

    // Random traffic; a request holds its payload until granted
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!(bus.a_req && !last_ga)) begin
        bus.a_req = ($urandom_range(0, 2) != 0); bus.a_we = 1'($urandom_range(0, 1));
        bus.a_addr = 14'($urandom()); bus.a_conf = 3'($urandom()); bus.a_wdata = $urandom();
      end
      if (!(bus.b_req && !last_gb)) begin
        bus.b_req = ($urandom_range(0, 2) != 0); bus.b_we = 1'($urandom_range(0, 1));
        bus.b_addr = 14'($urandom()); bus.b_conf = 3'($urandom()); bus.b_wdata = $urandom();
      end
      at_neg(); next();
    end
    rst = 1'b0; bus.a_req = 1'b0; bus.b_req = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      at_neg(); next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
